// File: rtl/clap_sound_gen.sv
// Clap burst synthesizer: decaying LFSR-noise bursts separated by silent gaps, streamed over valid/ready.
// Optional macro CLAP_ATTACK_EN adds an 8-sample attack ramp at the start of each burst.
module clap_sound_gen #(
  parameter int SAMPLE_W     = 16,
  parameter int CLAP_LEN     = 4800,
  parameter int DECAY_PERIOD = 600,
  parameter int GAP_LEN      = 2400
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trigger,
  input  logic [1:0]          num_claps,
  input  logic                sample_ready,
  output logic                sample_valid,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                busy,
  output logic                done
);

  localparam int IDX_W = $clog2(CLAP_LEN + 1);
  localparam int GAP_W = $clog2(GAP_LEN + 1);
  localparam int DEC_W = $clog2(DECAY_PERIOD + 1);
  localparam int SH_W  = $clog2(SAMPLE_W);

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, GAP = 2'd2} state_t;

  state_t              state_r, state_s;
  logic [15:0]         lfsr_r, lfsr_s, lfsr_adv_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [GAP_W-1:0]    gap_r, gap_s;
  logic [DEC_W-1:0]    dec_r, dec_s;
  logic [SH_W-1:0]     dsh_r, dsh_s;
  logic [1:0]          claps_r, claps_s;
  logic                valid_s, busy_s, done_s, xfer_s, dec_en_s;
  logic [SAMPLE_W-1:0] out_s;

  function automatic logic [SAMPLE_W-1:0] shape(input logic [15:0] l, input logic [SH_W-1:0] sh);
    logic signed [SAMPLE_W-1:0] s;
    s = l[15 -: SAMPLE_W];
    return s >>> sh;
  endfunction

`ifdef CLAP_ATTACK_EN
  localparam logic [SH_W-1:0] START_SH = SH_W'(3);
  assign dec_en_s = (idx_r >= IDX_W'(8));

  function automatic logic [SH_W-1:0] burst_shift(input logic [IDX_W-1:0] idx, input logic [SH_W-1:0] dsh);
    return (idx < IDX_W'(8)) ? SH_W'(2'd3 - idx[2:1]) : dsh;
  endfunction
`else
  localparam logic [SH_W-1:0] START_SH = SH_W'(0);
  assign dec_en_s = 1'b1;

  function automatic logic [SH_W-1:0] burst_shift(input logic [IDX_W-1:0] idx, input logic [SH_W-1:0] dsh);
    return (idx == idx) ? dsh : dsh;
  endfunction
`endif

  assign xfer_s     = sample_valid && sample_ready;
  assign lfsr_adv_s = {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};

  // State and datapath registers; everything holds unless the next-state logic changes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      lfsr_r       <= 16'hACE1;
      idx_r        <= '0;
      gap_r        <= '0;
      dec_r        <= '0;
      dsh_r        <= '0;
      claps_r      <= 2'd0;
      sample_valid <= 1'b0;
      sample_out   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_r      <= state_s;
      lfsr_r       <= lfsr_s;
      idx_r        <= idx_s;
      gap_r        <= gap_s;
      dec_r        <= dec_s;
      dsh_r        <= dsh_s;
      claps_r      <= claps_s;
      sample_valid <= valid_s;
      sample_out   <= out_s;
      busy         <= busy_s;
      done         <= done_s;
    end
  end

  // Next-state and next-output logic; a stall (no transfer) leaves every default untouched.
  always_comb begin
    state_s = state_r;
    lfsr_s  = lfsr_r;
    idx_s   = idx_r;
    gap_s   = gap_r;
    dec_s   = dec_r;
    dsh_s   = dsh_r;
    claps_s = claps_r;
    valid_s = sample_valid;
    out_s   = sample_out;
    busy_s  = busy;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        valid_s = 1'b0;
        // The done cycle still counts as the tail of the previous sequence.
        if (trigger && !done) begin
          claps_s = (num_claps == 2'd0) ? 2'd1 : num_claps;
          state_s = BURST;
          busy_s  = 1'b1;
          valid_s = 1'b1;
          idx_s   = '0;
          dec_s   = '0;
          dsh_s   = '0;
          out_s   = shape(lfsr_r, START_SH);
        end else begin
          busy_s  = 1'b0;
        end
      end
      BURST: begin
        if (xfer_s) begin
          lfsr_s = lfsr_adv_s;
          if (idx_r == IDX_W'(CLAP_LEN - 1)) begin
            out_s = '0;
            if (claps_r > 2'd1) begin
              claps_s = claps_r - 2'd1;
              state_s = GAP;
              gap_s   = '0;
            end else begin
              state_s = IDLE;
              valid_s = 1'b0;
              busy_s  = 1'b0;
              done_s  = 1'b1;
            end
          end else begin
            idx_s = idx_r + IDX_W'(1);
            if (dec_en_s && (dec_r == DEC_W'(DECAY_PERIOD - 1))) begin
              dec_s = '0;
              dsh_s = (dsh_r == SH_W'(SAMPLE_W - 1)) ? dsh_r : dsh_r + SH_W'(1);
            end else if (dec_en_s) begin
              dec_s = dec_r + DEC_W'(1);
            end else begin
              dec_s = dec_r;
            end
            out_s = shape(lfsr_adv_s, burst_shift(idx_s, dsh_s));
          end
        end else begin
          lfsr_s = lfsr_r;
        end
      end
      GAP: begin
        if (xfer_s && (gap_r == GAP_W'(GAP_LEN - 1))) begin
          state_s = BURST;
          idx_s   = '0;
          dec_s   = '0;
          dsh_s   = '0;
          out_s   = shape(lfsr_r, START_SH);
        end else if (xfer_s) begin
          gap_s   = gap_r + GAP_W'(1);
        end else begin
          gap_s   = gap_r;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        busy_s  = 1'b0;
        out_s   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_clap_sound_gen.sv
// Self-checking bench for clap_sound_gen: a queue of expected transferred samples built from the
// LFSR/decay rules, compared on every cycle, with randomized ready, trigger noise and mid-run reset.
module tb_clap_sound_gen;
  localparam int W = 16, CL = 16, DP = 4, GL = 8;

  logic         clk = 1'b0;
  logic         reset, trigger, sample_ready;
  logic [1:0]   num_claps;
  logic         sample_valid, busy, done;
  logic [W-1:0] sample_out;

  int           checks = 0, errors = 0, xfers = 0;
  bit           mon_en = 1'b0, done_exp = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] log_q[$];
  logic [15:0]  m_lfsr = 16'hACE1;

`ifdef CLAP_ATTACK_EN
  localparam logic [15:0] FIRST0 = 16'hF59C, FIRST1 = 16'h0B38;
`else
  localparam logic [15:0] FIRST0 = 16'hACE1, FIRST1 = 16'h59C3;
`endif

  always #5 clk = ~clk;

  clap_sound_gen #(.SAMPLE_W(W), .CLAP_LEN(CL), .DECAY_PERIOD(DP), .GAP_LEN(GL)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .num_claps(num_claps),
    .sample_ready(sample_ready), .sample_valid(sample_valid), .sample_out(sample_out),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int shift_for(input int i);
    int s;
`ifdef CLAP_ATTACK_EN
    if (i < 8) return 3 - i / 2;
    s = (i - 8) / DP;
`else
    s = i / DP;
`endif
    if (s > W - 1) s = W - 1;
    return s;
  endfunction

  task automatic build(input logic [1:0] n);
    int nc;
    logic signed [W-1:0] v;
    nc = (n == 2'd0) ? 1 : int'(n);
    for (int c = 0; c < nc; c++) begin
      for (int i = 0; i < CL; i++) begin
        v = m_lfsr;
        exp_q.push_back(v >>> shift_for(i));
        m_lfsr = step(m_lfsr);
      end
      if (c < nc - 1)
        for (int g = 0; g < GL; g++) exp_q.push_back('0);
    end
  endtask

  // Per-cycle compare against the expected stream; a pop means a transfer happens at the next edge.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      bit act;
      act = (exp_q.size() > 0);
      chk("valid", sample_valid, act);
      chk("busy", busy, act);
      chk("done", done, done_exp);
      if (sample_valid && act) chk("sample", sample_out, exp_q[0]);
      done_exp = 1'b0;
      if (sample_valid && sample_ready && act) begin
        log_q.push_back(sample_out);
        void'(exp_q.pop_front());
        xfers++;
        if (exp_q.size() == 0) done_exp = 1'b1;
      end
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    reset = 1'b1;
    trigger = 1'b0;
    sample_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    done_exp = 1'b0;
    m_lfsr = 16'hACE1;
    chk("rst_valid", sample_valid, 0);
    chk("rst_out", sample_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    mon_en = 1'b1;
  endtask

  task automatic run(input logic [1:0] n, input bit rnd, input bit noise, input int abort_at);
    int budget;
    log_q.delete();
    xfers = 0;
    num_claps = n;
    trigger = 1'b1;
    sample_ready = rnd ? 1'($urandom % 2) : 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    build(n);
    budget = 0;
    while (exp_q.size() > 0 && budget < 2000) begin
      @(posedge clk); #1;
      budget++;
      if (abort_at > 0 && xfers >= abort_at) begin
        do_reset();
        return;
      end
      sample_ready = rnd ? 1'($urandom % 2) : 1'b1;
      if (noise && exp_q.size() >= 2 && ($urandom % 4) == 0) begin
        trigger = 1'b1;
        num_claps = 2'($urandom);
      end else begin
        trigger = 1'b0;
      end
    end
    trigger = 1'b0;
    chk("timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    trigger = 1'b0;
    num_claps = 2'd0;
    sample_ready = 1'b1;
    do_reset();

    run(2'd1, 1'b0, 1'b0, 0);
    chk("t1_count", log_q.size(), 16);
    chk("t1_s0", log_q[0], FIRST0);
    chk("t1_s1", log_q[1], FIRST1);

    run(2'd2, 1'b0, 1'b0, 0);
    chk("t3_count", log_q.size(), 40);
    chk("t3_gap", log_q[20], 0);

    run(2'd0, 1'b0, 1'b0, 0);
    chk("t3_zero_count", log_q.size(), 16);

    do_reset();
    run(2'd2, 1'b1, 1'b1, 0);
    chk("t4_count", log_q.size(), 40);
    chk("t4_s0", log_q[0], FIRST0);

    run(2'd3, 1'b1, 1'b1, 10);
    chk("abort_xfers", xfers, 10);
    repeat (2) @(posedge clk);
    #1;
    run(2'd1, 1'b1, 1'b0, 0);
    chk("restart_s0", log_q[0], FIRST0);
    chk("restart_count", log_q.size(), 16);

    for (int k = 0; k < 6; k++) run(2'($urandom), 1'b1, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
